rc4_keystream_gen: RTL and testbench
====================================

Name: rc4_keystream_gen

Overview:
- Consumes the 24-bit key held in the HPS-writable key register and produces the RC4 keystream, one byte at a time, on a valid/ready stream.
- Runs the full RC4 sequence: S-box identity init, key-scheduling (KSA), then pseudo-random generation (PRGA).
- Downstream XOR/decrypt logic or an Avalon read FIFO consumes the stream.

Parameters:
- LENGTH, 32, number of keystream bytes produced per start (1..65535).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- key  input  24  key register value; key byte 0 = key[23:16], byte 1 = key[15:8], byte 2 = key[7:0]
- start  input  1  one-cycle pulse; begins a new run
- busy  output  1  high from start acceptance until the last byte is accepted
- done  output  1  one-cycle pulse when the last byte is accepted
- ks_data  output  8  keystream byte
- ks_valid  output  1  ks_data valid
- ks_ready  input  1  consumer accepts when ks_valid & ks_ready

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE.
  - busy, done, ks_valid = 0; ks_data = 0.
  - Indices i, j and the byte counter = 0. S-box contents are don't-care.
- IDLE: start=1 latches key into an internal register and goes to INIT. start is ignored in every other state, and key changes after latching have no effect.
- INIT, 256 cycles: write S[k]=k for k=0..255.
- KSA, 4 cycles per k, 256 iterations, j starts at 0:
  - RD_I: addr=i.
  - RD_J: j <= j + S[i] + keybyte[i mod 3] (mod 256); addr = new j.
  - WR_I: S[i] <= S[j].
  - WR_J: S[j] <= old S[i]; then i++.
  - After i=255 wraps to 0: set i=0, j=0 and go to PRGA.
- PRGA, per byte:
  - P_RD_I: i <= i+1; addr = new i.
  - P_RD_J: j <= j + S[i]; addr = new j.
  - P_WR_I: S[i] <= S[j].
  - P_WR_J: S[j] <= S[i].
  - P_RD_K: addr = S[i] + S[j] (mod 256, using the swapped values).
  - P_OUT: ks_data <= S[addr]; ks_valid=1.
  - ks_data and ks_valid hold stable until ks_ready.
  - On handshake: counter++. If counter == LENGTH, pulse done, clear busy, go to IDLE. Otherwise go to P_RD_I next cycle.
- Latency: with start sampled at edge 0, ks_valid first rises after edge 1286 (256 + 1024 + 6). Each subsequent byte comes 6 cycles after the previous handshake.
- All index arithmetic is 8-bit and wraps mod 256; the byte counter is 16-bit.
- ks_ready held high: no stall.
- ks_ready low indefinitely: the FSM holds in P_OUT and the S-box is not modified.
- start in the same cycle as the final handshake is ignored, because the FSM is not yet in IDLE. start is accepted in the following cycle.

Decomposition:
- Shared package rc4_pkg:
  - FSM state encoding.
  - Constants SBOX_DEPTH=256 and KEY_BYTES=3.
  - Cycle constants INIT_CYCLES=256, KSA_CYCLES_PER_ITER=4, PRGA_CYCLES_PER_BYTE=6.
- Sub-module rc4_sbox_ram: 256x8 single-port RAM with synchronous read and write (inferred M10K), ports clk, addr, wdata, we, rdata.
- The FSM, indices and key/byte-select logic stay in rc4_keystream_gen.

Test Plan:
- key=24'h4B6579 ("Key"), LENGTH=10, ks_ready=1, pulse start -> bytes EB 9F 77 81 B7 34 CA 72 A7 19; done pulses once; busy falls in the same cycle.
- Same key with ks_ready toggled pseudo-randomly -> identical byte sequence; ks_data stable while ks_valid & !ks_ready; no byte lost or duplicated.
- Pulse start, then cycle-count to the first ks_valid with ks_ready=1 -> rises exactly 1286 cycles after start; each later byte 6 cycles after the previous handshake.
- Pulse start again during KSA and during P_OUT, and change key mid-run -> ignored; output equals the original key's stream.
- Assert reset_n low mid-KSA, then release and start with key=24'h000000 -> outputs at reset value; fresh run produces the correct keystream for the all-zero key (first byte 0xDE, checked against the golden model).
- Two back-to-back runs with different keys, start asserted the cycle after done -> second stream matches the golden model; no state leaks from the first run.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 keystream types and constants: FSM encoding, S-box geometry and per-phase cycle counts.
// No logic; key_byte selects one byte of the 24-bit key, MSB first.
package rc4_pkg;

   localparam int SBOX_DEPTH           = 256;
   localparam int KEY_BYTES            = 3;
   localparam int INIT_CYCLES          = 256;
   localparam int KSA_CYCLES_PER_ITER  = 4;
   localparam int PRGA_CYCLES_PER_BYTE = 6;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_RD_I,
      ST_RD_J,
      ST_WR_I,
      ST_WR_J,
      ST_P_RD_I,
      ST_P_RD_J,
      ST_P_WR_I,
      ST_P_WR_J,
      ST_P_RD_K,
      ST_P_OUT
   } state_e;

   function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = key[23:16];
         2'd1:    b = key[15:8];
         default: b = key[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/rc4_sbox_ram.sv
// 256x8 single-port S-box RAM, synchronous read and write, read-first on a same-address write.
// One-cycle read latency; no backpressure, contents are not reset.
module rc4_sbox_ram
   import rc4_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic       we,
   output logic [7:0] rdata
);

   logic [7:0] mem_q [SBOX_DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/rc4_keystream_gen.sv
// RC4 keystream generator: S-box init, KSA, then one PRGA byte per valid/ready handshake.
// First byte valid 1286 cycles after start, then 6 cycles after each handshake; stalls in P_OUT with the S-box untouched.
module rc4_keystream_gen
   import rc4_pkg::*;
#(
   parameter int unsigned LENGTH = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [23:0] key,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [7:0]  ks_data,
   output logic        ks_valid,
   input  logic        ks_ready
);

   localparam logic [15:0] LEN16    = 16'(LENGTH);
   localparam logic [7:0]  LAST_IDX = 8'(SBOX_DEPTH - 1);
   localparam logic [7:0]  INIT_END = 8'(INIT_CYCLES - 1);
   localparam logic [1:0]  KSEL_END = 2'(KEY_BYTES - 1);

   state_e      state_q, state_d;
   logic [7:0]  i_q, i_d, j_q, j_d;
   logic [1:0]  ksel_q, ksel_d;
   logic [7:0]  si_q, si_d, sj_q, sj_d;
   logic [15:0] cnt_q, cnt_d;
   logic [23:0] key_q, key_d;
   logic        busy_q, busy_d, done_q, done_d, vld_q, vld_d;
   logic [7:0]  dat_q, dat_d;

   logic [7:0]  ram_addr, ram_wdata, ram_rdata;
   logic        ram_we;

   rc4_sbox_ram u_sbox (
      .clk   (clk),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .we    (ram_we),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      ksel_d    = ksel_q;
      si_d      = si_q;
      sj_d      = sj_q;
      cnt_d     = cnt_q;
      key_d     = key_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      vld_d     = vld_q;
      dat_d     = dat_q;
      ram_addr  = i_q;
      ram_wdata = ram_rdata;
      ram_we    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_d   = key;
               i_d     = 8'd0;
               j_d     = 8'd0;
               ksel_d  = 2'd0;
               cnt_d   = 16'd0;
               busy_d  = 1'b1;
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            ram_wdata = i_q;
            ram_we    = 1'b1;
            i_d       = i_q + 8'd1;
            if (i_q == INIT_END) state_d = ST_RD_I;
         end
         ST_RD_I: state_d = ST_RD_J;
         ST_RD_J: begin
            // ram_rdata holds S[i] here; the new j addresses the next read directly
            j_d      = j_q + ram_rdata + key_byte(key_q, ksel_q);
            si_d     = ram_rdata;
            ram_addr = j_d;
            state_d  = ST_WR_I;
         end
         ST_WR_I: begin
            ram_we  = 1'b1;
            state_d = ST_WR_J;
         end
         ST_WR_J: begin
            ram_addr  = j_q;
            ram_wdata = si_q;
            ram_we    = 1'b1;
            i_d       = i_q + 8'd1;
            ksel_d    = (ksel_q == KSEL_END) ? 2'd0 : ksel_q + 2'd1;
            if (i_q == LAST_IDX) begin
               i_d     = 8'd0;
               j_d     = 8'd0;
               state_d = ST_P_RD_I;
            end else begin
               state_d = ST_RD_I;
            end
         end
         ST_P_RD_I: begin
            i_d      = i_q + 8'd1;
            ram_addr = i_d;
            state_d  = ST_P_RD_J;
         end
         ST_P_RD_J: begin
            j_d      = j_q + ram_rdata;
            si_d     = ram_rdata;
            ram_addr = j_d;
            state_d  = ST_P_WR_I;
         end
         ST_P_WR_I: begin
            sj_d    = ram_rdata;
            ram_we  = 1'b1;
            state_d = ST_P_WR_J;
         end
         ST_P_WR_J: begin
            ram_addr  = j_q;
            ram_wdata = si_q;
            ram_we    = 1'b1;
            state_d   = ST_P_RD_K;
         end
         ST_P_RD_K: begin
            ram_addr = si_q + sj_q;
            state_d  = ST_P_OUT;
         end
         ST_P_OUT: begin
            ram_addr = si_q + sj_q;
            if (!vld_q) begin
               dat_d = ram_rdata;
               vld_d = 1'b1;
            end else if (ks_ready) begin
               vld_d = 1'b0;
               cnt_d = cnt_q + 16'd1;
               if (cnt_d == LEN16) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_P_RD_I;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         i_q     <= 8'd0;
         j_q     <= 8'd0;
         ksel_q  <= 2'd0;
         si_q    <= 8'd0;
         sj_q    <= 8'd0;
         cnt_q   <= 16'd0;
         key_q   <= 24'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         vld_q   <= 1'b0;
         dat_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         ksel_q  <= ksel_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         vld_q   <= vld_d;
         dat_q   <= dat_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign ks_valid = vld_q;
   assign ks_data  = dat_q;

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Directed bench for rc4_keystream_gen: known "Key" vectors, stalls, ignored starts, reset mid-run, back-to-back runs.
// Outputs sampled and inputs driven on the falling clock edge.
module tb_rc4_keystream_gen;

   localparam int LEN = 10;
   localparam logic [23:0] KEY_STR = 24'h4B6579;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [23:0] key = 24'd0;
   logic        start = 1'b0;
   logic        ks_ready = 1'b0;
   logic        busy, done, ks_valid;
   logic [7:0]  ks_data;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int first_vld_cyc;
   int min_gap, max_gap;

   rc4_keystream_gen #(.LENGTH(LEN)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .key      (key),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .ks_data  (ks_data),
      .ks_valid (ks_valid),
      .ks_ready (ks_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load_key_vec();
      exp_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
   endtask

   // Textbook RC4 on a 3-byte key, first LEN bytes into exp_q
   task automatic gen_ref(input logic [23:0] k);
      logic [7:0] s[256];
      logic [7:0] kb[3];
      logic [7:0] i, j, t;
      kb[0] = k[23:16];
      kb[1] = k[15:8];
      kb[2] = k[7:0];
      for (int x = 0; x < 256; x++) s[x] = 8'(x);
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         j = j + s[x] + kb[x % 3];
         t = s[x]; s[x] = s[j]; s[j] = t;
      end
      i = 8'd0;
      j = 8'd0;
      exp_q.delete();
      for (int b = 0; b < LEN; b++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i]; s[i] = s[j]; s[j] = t;
         exp_q.push_back(s[8'(s[i] + s[j])]);
      end
   endtask

   // Caller is at a falling edge; start is driven now so the next rising edge is edge 0.
   task automatic run_stream(input logic [23:0] k, input bit rnd_rdy, input bit poke, input bit start_at_last);
      int cyc, taken, acc_cyc, early_done, gap;
      bit held, want_gap, rdy;
      logic [7:0] held_dat;
      got_q.delete();
      first_vld_cyc = -1;
      min_gap = 1 << 30;
      max_gap = 0;
      taken = 0; acc_cyc = 0; early_done = 0;
      held = 1'b0; want_gap = 1'b0; held_dat = 8'd0;
      key = k;
      start = 1'b1;
      cyc = -1;
      while (taken < LEN && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         start = poke && (cyc == 400);
         if (poke && cyc == 2) key = ~k;
         if (cyc == 0) begin
            check_val("busy_after_start", 32'(busy), 32'd1);
            check_val("done_low_after_start", 32'(done), 32'd0);
         end
         if (done) early_done++;
         if (held) begin
            check_val("hold_valid", 32'(ks_valid), 32'd1);
            check_val("hold_data", 32'(ks_data), 32'(held_dat));
         end
         if (ks_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (ks_valid && want_gap) begin
            gap = cyc - acc_cyc;
            if (gap < min_gap) min_gap = gap;
            if (gap > max_gap) max_gap = gap;
            want_gap = 1'b0;
         end
         rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         ks_ready = rdy;
         if (ks_valid && rdy) begin
            got_q.push_back(ks_data);
            taken++;
            held = 1'b0;
            acc_cyc = cyc;
            want_gap = 1'b1;
            if (start_at_last && taken == LEN) begin
               start = 1'b1;
               key = 24'h123456;
            end
         end else if (ks_valid) begin
            held = 1'b1;
            held_dat = ks_data;
            if (poke) start = 1'b1;
         end
      end
      check_val("bytes_taken", 32'(taken), 32'(LEN));
      check_val("no_early_done", 32'(early_done), 32'd0);
      @(negedge clk);
      start = 1'b0;
      ks_ready = 1'b0;
      check_val("done_pulse", 32'(done), 32'd1);
      check_val("busy_clear", 32'(busy), 32'd0);
      check_val("valid_clear", 32'(ks_valid), 32'd0);
      for (int b = 0; b < LEN; b++)
         check_val($sformatf("byte%0d", b),
                   (b < got_q.size()) ? 32'(got_q[b]) : 32'hDEAD, 32'(exp_q[b]));
   endtask

   initial begin
      @(negedge clk);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_valid", 32'(ks_valid), 32'd0);
      check_val("rst_data", 32'(ks_data), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // "Key", consumer always ready: exact latency and 6-cycle spacing (7 falling edges accept-to-valid)
      load_key_vec();
      run_stream(KEY_STR, 1'b0, 1'b0, 1'b0);
      check_val("first_valid_cycle", 32'(first_vld_cyc), 32'd1286);
      check_val("min_gap", 32'(min_gap), 32'd7);
      check_val("max_gap", 32'(max_gap), 32'd7);
      @(negedge clk);
      check_val("done_one_cycle", 32'(done), 32'd0);

      // Random backpressure
      load_key_vec();
      run_stream(KEY_STR, 1'b1, 1'b0, 1'b0);
      check_val("stall_min_gap", 32'(min_gap), 32'd7);
      check_val("stall_max_gap", 32'(max_gap), 32'd7);
      @(negedge clk);

      // Starts during KSA and P_OUT, key changed after latch
      load_key_vec();
      run_stream(KEY_STR, 1'b1, 1'b1, 1'b0);
      check_val("poke_first_valid", 32'(first_vld_cyc), 32'd1286);
      @(negedge clk);

      // Reset mid-KSA clears outputs, then all-zero key run
      key = KEY_STR;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (600) @(negedge clk);
      check_val("midrun_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check_val("rst2_busy", 32'(busy), 32'd0);
      check_val("rst2_done", 32'(done), 32'd0);
      check_val("rst2_valid", 32'(ks_valid), 32'd0);
      check_val("rst2_data", 32'(ks_data), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      gen_ref(24'h000000);
      run_stream(24'h000000, 1'b0, 1'b0, 1'b0);
      check_val("zero_key_byte0", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'hDE);
      @(negedge clk);

      // Back-to-back: start on the final handshake is ignored, start the cycle after done is taken
      load_key_vec();
      run_stream(KEY_STR, 1'b0, 1'b0, 1'b1);
      gen_ref(24'hC0FFEE);
      run_stream(24'hC0FFEE, 1'b1, 1'b0, 1'b0);
      check_val("b2b_first_valid", 32'(first_vld_cyc), 32'd1286);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
